// File: rtl/cache_miss_ctrl.sv
// Purpose : CPU-side controller for a 128-byte direct-mapped cache with read-miss fill and write-through-allocate.
// Latency : a read hit completes 2 edges after acceptance, a read miss 4+k edges, and a write 3+k edges (k = memory wait cycles).
// Backpress: each access blocks until mem_ack arrives or MEM_TIMEOUT expires; cpu_req is sampled only in IDLE.
//
// Ports:
//   clk_1, rst (synchronous, active-low)
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  -> request; cpu_rdata/cpu_ready/cpu_err <- one-cycle completion
//   c_w_en/c_addr/c_wdata -> cache array; c_rdata/c_hit <- combinational lookup result
//   mem_req/mem_we/mem_addr/mem_wdata -> main memory; mem_rdata/mem_ack <- response
// Optional build macro CACHE_STATS_EN adds the saturating hit_cnt/miss_cnt outputs.
module cache_miss_ctrl #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic        clk_1,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ready,
    output logic        cpu_err,
    output logic        c_w_en,
    output logic [15:0] c_addr,
    output logic [7:0]  c_wdata,
    input  logic [7:0]  c_rdata,
    input  logic        c_hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MEM_RD,
        S_FILL,
        S_WR,
        S_MEM_WR,
        S_DONE
    } state_t;

    // The wait is aborted on the edge at which the count would reach MEM_TIMEOUT.
    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state_q;
    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        err_q;
    logic [7:0]  cnt_q;
    logic        ready_q;
    logic        c_w_en_q;
    logic        mem_req_q;
    logic        mem_we_q;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;
`endif

    always_ff @(posedge clk_1) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b0;
            c_w_en_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
`ifdef CACHE_STATS_EN
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
`endif
        end else begin
            // Single-cycle strobes; only the transitions below raise them.
            ready_q  <= 1'b0;
            c_w_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        err_q   <= 1'b0;
                        if (cpu_we) begin
                            state_q  <= S_WR;
                            c_w_en_q <= 1'b1;
                        end else begin
                            state_q <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (c_hit) begin
                        rdata_q <= c_rdata;
                        state_q <= S_DONE;
`ifdef CACHE_STATS_EN
                        if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
`endif
                    end else begin
                        state_q   <= S_MEM_RD;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        cnt_q     <= '0;
`ifdef CACHE_STATS_EN
                        if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
`endif
                    end
                end
                S_MEM_RD: begin
                    // An ack on the final count edge still wins over the timeout.
                    if (mem_ack) begin
                        rdata_q   <= mem_rdata;
                        mem_req_q <= 1'b0;
                        c_w_en_q  <= 1'b1;
                        state_q   <= S_FILL;
                    end else if (cnt_q == TO_LAST) begin
                        rdata_q   <= 8'hFF;
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_FILL: begin
                    state_q <= S_DONE;
                end
                S_WR: begin
                    state_q   <= S_MEM_WR;
                    mem_req_q <= 1'b1;
                    mem_we_q  <= 1'b1;
                    cnt_q     <= '0;
                end
                S_MEM_WR: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (cnt_q == TO_LAST) begin
                        err_q     <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    // The completion pulse is registered off DONE, so it is seen
                    // in the following IDLE cycle, where a new request may be taken.
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign cpu_err   = err_q;
    assign c_w_en    = c_w_en_q;
    assign c_addr    = addr_q;
    // Writes store the CPU byte; fills store the byte fetched into rdata_q.
    assign c_wdata   = we_q ? wdata_q : rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
`ifdef CACHE_STATS_EN
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Purpose : directed vector bench for cache_miss_ctrl with a behavioural cache array and memory.
// Latency : latencies are counted in rising edges after the edge that accepts the request.
// Backpress: the memory model acks after a programmable number of waiting cycles, or never.
module tb_cache_miss_ctrl;

    logic        clk_1 = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;
    logic        c_w_en;
    logic [15:0] c_addr;
    logic [7:0]  c_wdata;
    logic [7:0]  c_rdata;
    logic        c_hit;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    always #5 clk_1 = ~clk_1;

    cache_miss_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk_1(clk_1), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_err(cpu_err),
        .c_w_en(c_w_en), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_hit(c_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    // Direct-mapped cache array: index = addr[6:0], tag = addr[15:7].
    bit   [7:0] cdata  [128];
    bit   [8:0] ctag   [128];
    bit         cvalid [128];
    assign c_hit   = cvalid[c_addr[6:0]] && (ctag[c_addr[6:0]] == c_addr[15:7]);
    assign c_rdata = cdata[c_addr[6:0]];
    always @(posedge clk_1) begin
        if (c_w_en) begin
            cdata[c_addr[6:0]]  <= c_wdata;
            ctag[c_addr[6:0]]   <= c_addr[15:7];
            cvalid[c_addr[6:0]] <= 1'b1;
        end
    end

    // Memory: ack is raised once req has waited ack_k cycles, and drops with req.
    bit   [7:0]  mem_arr [65536];
    int          ack_k;
    bit          never_ack;
    int          req_cnt;
    logic [15:0] last_wr_addr;
    logic [7:0]  last_wr_data;
    assign mem_ack   = mem_req && !never_ack && (req_cnt >= ack_k);
    assign mem_rdata = mem_arr[mem_addr];
    always @(posedge clk_1) begin
        if (!mem_req) req_cnt <= 0;
        else if (!mem_ack) req_cnt <= req_cnt + 1;
        if (mem_req && mem_we && mem_ack) begin
            last_wr_addr <= mem_addr;
            last_wr_data <= mem_wdata;
        end
    end

    int wen_total = 0;
    always @(negedge clk_1) if (c_w_en === 1'b1) wen_total++;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cpu_ready"}, 32'(cpu_ready), 0);
        check({tag, " cpu_err"},   32'(cpu_err),   0);
        check({tag, " cpu_rdata"}, 32'(cpu_rdata), 0);
        check({tag, " c_w_en"},    32'(c_w_en),    0);
        check({tag, " c_addr"},    32'(c_addr),    0);
        check({tag, " c_wdata"},   32'(c_wdata),   0);
        check({tag, " mem_req"},   32'(mem_req),   0);
        check({tag, " mem_we"},    32'(mem_we),    0);
        check({tag, " mem_addr"},  32'(mem_addr),  0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
    endtask

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack_k;      // memory wait cycles before ack
        logic        never;      // memory never acks
        logic [7:0]  mem_byte;   // memory content at addr for reads
        logic        chk_rdata;
        logic [7:0]  exp_rdata;
        logic        exp_err;
        int          exp_lat;    // ready seen in the cycle after this edge
        int          exp_wait;   // cycles mem_req is high without ack
        int          exp_req;    // total cycles mem_req is high
        int          exp_wen;    // number of c_w_en pulses
    } vec_t;

    // Called at a falling edge with the DUT idle; returns at the falling edge where ready is seen.
    task automatic do_access(input vec_t v, input int idx);
        int   lat = -1, waitc = 0, totc = 0, wenc = 0;
        logic [15:0] wa = '0, ma = '0;
        logic [7:0]  wd = '0, md = '0, rd = '0;
        logic        mwe = 1'b0, er = 1'b0;
        string p;
        p = $sformatf("v%0d", idx);
        ack_k = v.ack_k;
        never_ack = v.never;
        if (!v.we) mem_arr[v.addr] = v.mem_byte;
        cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
        @(posedge clk_1);
        @(negedge clk_1);
        cpu_req = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) begin @(posedge clk_1); @(negedge clk_1); end
            if (c_w_en) begin wenc++; wa = c_addr; wd = c_wdata; end
            if (mem_req) begin
                if (totc == 0) begin mwe = mem_we; ma = mem_addr; md = mem_wdata; end
                totc++;
                if (!mem_ack) waitc++;
            end
            if (cpu_ready) begin lat = n; rd = cpu_rdata; er = cpu_err; break; end
        end
        check({p, " latency"},   32'(lat),   32'(v.exp_lat));
        check({p, " req_wait"},  32'(waitc), 32'(v.exp_wait));
        check({p, " req_total"}, 32'(totc),  32'(v.exp_req));
        check({p, " wen_count"}, 32'(wenc),  32'(v.exp_wen));
        check({p, " cpu_err"},   32'(er),    32'(v.exp_err));
        if (v.chk_rdata) check({p, " cpu_rdata"}, 32'(rd), 32'(v.exp_rdata));
        if (v.exp_wen > 0) begin
            check({p, " c_addr"},  32'(wa), 32'(v.addr));
            check({p, " c_wdata"}, 32'(wd), 32'(v.we ? v.wdata : v.mem_byte));
        end
        if (v.exp_req > 0) begin
            check({p, " mem_we"},   32'(mwe), 32'(v.we));
            check({p, " mem_addr"}, 32'(ma),  32'(v.addr));
            if (v.we) check({p, " mem_wdata"}, 32'(md), 32'(v.wdata));
        end
    endtask

    vec_t vecs [12];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        //          we    addr     wdata  k  nev  mem    chk  rdata  err lat wait req wen
        vecs[0]  = '{1'b0, 16'h1234, 8'h00, 3, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 7, 3, 4, 1}; // miss, ack on last count edge
        vecs[1]  = '{1'b0, 16'h1234, 8'h00, 0, 1'b0, 8'hEE, 1'b1, 8'hA5, 1'b0, 2, 0, 0, 0}; // hit
        vecs[2]  = '{1'b1, 16'h00F0, 8'h3C, 0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 3, 0, 1, 1}; // write, immediate ack
        vecs[3]  = '{1'b0, 16'h00F0, 8'h00, 0, 1'b0, 8'hEE, 1'b1, 8'h3C, 1'b0, 2, 0, 0, 0}; // allocated by write
        vecs[4]  = '{1'b0, 16'h0005, 8'h00, 0, 1'b0, 8'h11, 1'b1, 8'h11, 1'b0, 4, 0, 1, 1}; // miss
        vecs[5]  = '{1'b0, 16'h0085, 8'h00, 1, 1'b0, 8'h22, 1'b1, 8'h22, 1'b0, 5, 1, 2, 1}; // conflict miss
        vecs[6]  = '{1'b0, 16'h0005, 8'h00, 2, 1'b0, 8'h11, 1'b1, 8'h11, 1'b0, 6, 2, 3, 1}; // evicted, misses again
        vecs[7]  = '{1'b0, 16'hBEEF, 8'h00, 0, 1'b1, 8'h5E, 1'b1, 8'hFF, 1'b1, 6, 4, 4, 0}; // read timeout
        vecs[8]  = '{1'b0, 16'h0005, 8'h00, 0, 1'b0, 8'hEE, 1'b1, 8'h11, 1'b0, 2, 0, 0, 0}; // err cleared
        vecs[9]  = '{1'b1, 16'h1234, 8'h5A, 0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 6, 4, 4, 1}; // write timeout
        vecs[10] = '{1'b0, 16'h1234, 8'h00, 0, 1'b0, 8'hEE, 1'b1, 8'h5A, 1'b0, 2, 0, 0, 0}; // cache kept new byte
        vecs[11] = '{1'b0, 16'hBEEF, 8'h00, 0, 1'b0, 8'h5E, 1'b1, 8'h5E, 1'b0, 4, 0, 1, 1}; // timeout did not fill

        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        ack_k = 0; never_ack = 1'b0;
        repeat (3) @(posedge clk_1);
        @(negedge clk_1);
        check_all_zero("reset");
        rst = 1'b1;
        @(negedge clk_1);

        for (int i = 0; i < 12; i++) begin
            do_access(vecs[i], i);
            if (i == 2) begin
                check("mem write addr", 32'(last_wr_addr), 32'h00F0);
                check("mem write data", 32'(last_wr_data), 32'h3C);
            end
        end

        // Reset while waiting in MEM_RD: access dropped, nothing filled.
        begin
            int wen_base;
            vec_t v;
            mem_arr[16'h4444] = 8'h77;
            never_ack = 1'b1;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4444;
            @(posedge clk_1);
            @(negedge clk_1);
            cpu_req = 1'b0;
            repeat (2) @(posedge clk_1);
            @(negedge clk_1);
            check("midreset mem_req before", 32'(mem_req), 1);
            wen_base = wen_total;
            rst = 1'b0;
            @(posedge clk_1);
            @(negedge clk_1);
            check_all_zero("midreset");
            rst = 1'b1;
            never_ack = 1'b0;
            repeat (3) @(posedge clk_1);
            @(negedge clk_1);
            check("midreset no fill", 32'(wen_total - wen_base), 0);
            check("midreset stays idle", 32'({cpu_ready, mem_req}), 0);
            v = '{1'b0, 16'h4444, 8'h00, 0, 1'b0, 8'h77, 1'b1, 8'h77, 1'b0, 4, 0, 1, 1};
            do_access(v, 12);
        end

        // cpu_req held high: miss (k=2) then one hit, the hit accepted right after DONE.
        begin
            int ready_n [$];
            int totc = 0;
            logic [7:0] rds [$];
            mem_arr[16'h0300] = 8'h99;
            ack_k = 2; never_ack = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
            @(posedge clk_1);
            for (int n = 0; n < 14; n++) begin
                if (n > 0) @(posedge clk_1);
                @(negedge clk_1);
                if (mem_req) totc++;
                if (cpu_ready) begin ready_n.push_back(n); rds.push_back(cpu_rdata); end
                if (n == 9) cpu_req = 1'b0;
            end
            check("busy ready count", 32'(ready_n.size()), 2);
            if (ready_n.size() == 2) begin
                check("busy first ready edge",  32'(ready_n[0]), 6);
                check("busy second ready edge", 32'(ready_n[1]), 9);
                check("busy first rdata",  32'(rds[0]), 32'h99);
                check("busy second rdata", 32'(rds[1]), 32'h99);
            end
            check("busy mem_req cycles", 32'(totc), 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
